// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg
// Shared types and constants for the 3x3 streaming convolution engine:
//   mode_t       - output combine mode selected by cfg_mode
//   acc_width()  - accumulator width for a given pixel/coefficient width
//   SOBEL_GX/GY  - reset kernels, row-major, row 0 = oldest (top) line
package conv3x3_pkg;

   typedef enum logic [1:0] {
      MODE_ABS_A = 2'd0,
      MODE_ABS_B = 2'd1,
      MODE_SUM   = 2'd2,
      MODE_PASS  = 2'd3
   } mode_t;

   localparam mode_t DEFAULT_MODE = MODE_SUM;

   // 9 products of an unsigned pixel and a signed coefficient summed exactly
   function automatic int acc_width(input int pix_w, input int coef_w);
      return pix_w + coef_w + 4;
   endfunction

   localparam int SOBEL_GX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
   localparam int SOBEL_GY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

endpackage

// File: rtl/conv3x3_stream_engine_line_window.sv
// line_window_3x3
// Two IMG_W-deep line FIFOs feeding a 3x3 shift window. Everything advances
// only when en is high, so input bubbles freeze the window.
//   clk, rst (async, active-low), en (advance), pixel (newest sample)
//   taps[r*3+c]: r=0 oldest line, r=2 current line; c=0 oldest column, c=2 newest
module line_window_3x3 #(
   parameter int PIX_W = 12,
   parameter int IMG_W = 640
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [PIX_W-1:0]       pixel,
   output logic [8:0][PIX_W-1:0]  taps
);

   localparam int PTR_W = $clog2(IMG_W);

   logic [PIX_W-1:0] line1 [IMG_W];
   logic [PIX_W-1:0] line2 [IMG_W];
   logic [PTR_W-1:0] ptr;
   logic [PIX_W-1:0] rd1;
   logic [PIX_W-1:0] rd2;
   logic [PIX_W-1:0] win [3][3];

   // Same column one and two lines ago; the shared pointer keeps columns aligned
   assign rd1 = line1[ptr];
   assign rd2 = line2[ptr];

   // Line storage: contents are never reset, border zeroing hides stale data
   always_ff @(posedge clk) begin
      if (en) begin
         line1[ptr] <= pixel;
         line2[ptr] <= rd1;
      end
   end

   // Column pointer shared by both line FIFOs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (en) begin
         if (ptr == PTR_W'(IMG_W - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + PTR_W'(1);
         end
      end
   end

   // 3x3 window: each row shifts left and takes its line's sample on the right
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (en) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= rd2;
         win[1][2] <= rd1;
         win[2][2] <= pixel;
      end
   end

   // Flatten the window into row-major taps
   always_comb begin
      taps = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            taps[r*3 + c] = win[r][c];
         end
      end
   end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine
// Streaming 3x3 convolution on the grayscale path with two runtime-loadable
// signed kernels, selectable combine mode, output shift and saturation.
// One output per input pixel, fixed 3-cycle latency.
//   clk, rst            clock, asynchronous active-low reset
//   in_pixel/valid/sof  input stream (sof qualified by valid)
//   coef_wr/sel/idx/data  shadow kernel write (idx 9..15 ignored)
//   cfg_mode, cfg_shift shadow config, sampled every cycle
//   out_pixel/valid/sof output stream; out_pixel holds when out_valid=0
module conv3x3_stream_engine
   import conv3x3_pkg::*;
#(
   parameter int PIX_W   = 12,
   parameter int COEF_W  = 8,
   parameter int IMG_W   = 640,
   parameter int SHIFT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   in_pixel,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic               coef_wr,
   input  logic               coef_sel,
   input  logic [3:0]         coef_idx,
   input  logic [COEF_W-1:0]  coef_data,
   input  logic [1:0]         cfg_mode,
   input  logic [SHIFT_W-1:0] cfg_shift,
   output logic [PIX_W-1:0]   out_pixel,
   output logic               out_valid,
   output logic               out_sof
);

   localparam int ACC_W   = acc_width(PIX_W, COEF_W);
   localparam int SUM_W   = ACC_W + 1;
   localparam int X_W     = $clog2(IMG_W + 1);
   localparam int Y_W     = 16;
   localparam int PIX_MAX = (1 << PIX_W) - 1;

   // ---------------- position ----------------
   logic [X_W-1:0] x_cnt;
   logic [Y_W-1:0] y_cnt;
   logic [X_W-1:0] cur_x;
   logic [Y_W-1:0] cur_y;
   logic           border;

   // Position of the pixel on the input this cycle; sof restarts the frame
   always_comb begin
      cur_x = x_cnt;
      cur_y = y_cnt;
      if (in_sof) begin
         cur_x = '0;
         cur_y = '0;
      end else begin
         cur_x = x_cnt;
         cur_y = y_cnt;
      end
      border = (cur_x < X_W'(2)) || (cur_y < Y_W'(2));
   end

   // x/y counters: x wraps at line end, y saturates
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (in_valid) begin
         if (cur_x == X_W'(IMG_W - 1)) begin
            x_cnt <= '0;
            if (cur_y != '1) begin
               y_cnt <= cur_y + Y_W'(1);
            end else begin
               y_cnt <= cur_y;
            end
         end else begin
            x_cnt <= cur_x + X_W'(1);
            y_cnt <= cur_y;
         end
      end
   end

   // ---------------- configuration ----------------
   logic signed [COEF_W-1:0] sh_a   [9];
   logic signed [COEF_W-1:0] sh_b   [9];
   logic signed [COEF_W-1:0] act_a  [9];
   logic signed [COEF_W-1:0] act_b  [9];
   mode_t                    sh_mode;
   mode_t                    act_mode;
   logic [SHIFT_W-1:0]       sh_shift;
   logic [SHIFT_W-1:0]       act_shift;

   // Shadow bank: coefficient writes plus free-running mode/shift sampling
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) begin
            sh_a[i] <= COEF_W'(SOBEL_GX[i]);
            sh_b[i] <= COEF_W'(SOBEL_GY[i]);
         end
         sh_mode  <= DEFAULT_MODE;
         sh_shift <= '0;
      end else begin
         sh_mode  <= mode_t'(cfg_mode);
         sh_shift <= cfg_shift;
         if (coef_wr) begin
            for (int i = 0; i < 9; i++) begin
               if (coef_idx == 4'(i)) begin
                  if (coef_sel) begin
                     sh_b[i] <= coef_data;
                  end else begin
                     sh_a[i] <= coef_data;
                  end
               end
            end
         end
      end
   end

   // Active bank: loaded at sof so the whole frame runs on one consistent set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) begin
            act_a[i] <= COEF_W'(SOBEL_GX[i]);
            act_b[i] <= COEF_W'(SOBEL_GY[i]);
         end
         act_mode  <= DEFAULT_MODE;
         act_shift <= '0;
      end else if (in_valid && in_sof) begin
         act_a     <= sh_a;
         act_b     <= sh_b;
         act_mode  <= sh_mode;
         act_shift <= sh_shift;
      end
   end

   // ---------------- S1: window capture ----------------
   logic [8:0][PIX_W-1:0] taps;
   logic                  v1;
   logic                  sof1;
   logic                  zero1;

   line_window_3x3 #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W)
   ) u_window (
      .clk   (clk),
      .rst   (rst),
      .en    (in_valid),
      .pixel (in_pixel),
      .taps  (taps)
   );

   // S1 control: valid, sof and border flag travel with the window update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1    <= 1'b0;
         sof1  <= 1'b0;
         zero1 <= 1'b0;
      end else begin
         v1    <= in_valid;
         sof1  <= in_valid & in_sof;
         zero1 <= border;
      end
   end

   // ---------------- S2: multiply-accumulate ----------------
   logic signed [ACC_W-1:0] sum_a;
   logic signed [ACC_W-1:0] sum_b;
   logic signed [ACC_W-1:0] tap_ext;
   logic signed [ACC_W-1:0] acc_a;
   logic signed [ACC_W-1:0] acc_b;
   logic [PIX_W-1:0]        centre;
   logic                    v2;
   logic                    sof2;
   logic                    zero2;
   mode_t                   mode2;
   logic [SHIFT_W-1:0]      shift2;

   // Exact 9-tap sums; pixels zero-extended, coefficients sign-extended
   always_comb begin
      sum_a   = '0;
      sum_b   = '0;
      tap_ext = '0;
      for (int i = 0; i < 9; i++) begin
         tap_ext = signed'({{(ACC_W-PIX_W){1'b0}}, taps[i]});
         sum_a   = sum_a + tap_ext * ACC_W'(act_a[i]);
         sum_b   = sum_b + tap_ext * ACC_W'(act_b[i]);
      end
   end

   // S2 registers; mode/shift are captured here so a frame's tail keeps its own config
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_a  <= '0;
         acc_b  <= '0;
         centre <= '0;
         v2     <= 1'b0;
         sof2   <= 1'b0;
         zero2  <= 1'b0;
         mode2  <= DEFAULT_MODE;
         shift2 <= '0;
      end else begin
         acc_a  <= sum_a;
         acc_b  <= sum_b;
         centre <= taps[4];
         v2     <= v1;
         sof2   <= sof1;
         zero2  <= zero1;
         mode2  <= act_mode;
         shift2 <= act_shift;
      end
   end

   // ---------------- S3: abs / combine / shift / saturate ----------------
   logic [ACC_W-1:0] abs_a;
   logic [ACC_W-1:0] abs_b;
   logic [SUM_W-1:0] combined;
   logic [SUM_W-1:0] shifted;
   logic [PIX_W-1:0] result;

   // Magnitudes are unsigned ACC_W, so the most negative sum still fits
   always_comb begin
      abs_a    = acc_a;
      abs_b    = acc_b;
      combined = '0;
      shifted  = '0;
      result   = '0;
      if (acc_a[ACC_W-1]) begin
         abs_a = -acc_a;
      end else begin
         abs_a = acc_a;
      end
      if (acc_b[ACC_W-1]) begin
         abs_b = -acc_b;
      end else begin
         abs_b = acc_b;
      end
      case (mode2)
         MODE_ABS_A: combined = {1'b0, abs_a};
         MODE_ABS_B: combined = {1'b0, abs_b};
         MODE_SUM:   combined = {1'b0, abs_a} + {1'b0, abs_b};
         MODE_PASS:  combined = SUM_W'(centre);
         default:    combined = '0;
      endcase
      shifted = combined >> shift2;
      if (zero2) begin
         result = '0;
      end else if (shifted > SUM_W'(PIX_MAX)) begin
         result = '1;
      end else begin
         result = shifted[PIX_W-1:0];
      end
   end

   // Output registers; pixel holds between valid outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_pixel <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end else begin
         out_valid <= v2;
         out_sof   <= sof2;
         if (v2) begin
            out_pixel <= result;
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// tb_conv3x3_stream_engine
// Scoreboard bench: each driven pixel pushes its expected output, computed
// directly from the stored frame image; the monitor pops and compares on
// every out_valid and checks out_valid against in_valid three edges earlier.
module tb_conv3x3_stream_engine;
   import conv3x3_pkg::*;

   localparam int PIX_W   = 12;
   localparam int COEF_W  = 8;
   localparam int IMG_W   = 8;
   localparam int SHIFT_W = 4;
   localparam int ROWS    = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [PIX_W-1:0]   in_pixel;
   logic               in_valid;
   logic               in_sof;
   logic               coef_wr;
   logic               coef_sel;
   logic [3:0]         coef_idx;
   logic [COEF_W-1:0]  coef_data;
   logic [1:0]         cfg_mode;
   logic [SHIFT_W-1:0] cfg_shift;
   logic [PIX_W-1:0]   out_pixel;
   logic               out_valid;
   logic               out_sof;

   always #5 clk = ~clk;

   conv3x3_stream_engine #(
      .PIX_W   (PIX_W),
      .COEF_W  (COEF_W),
      .IMG_W   (IMG_W),
      .SHIFT_W (SHIFT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_pixel  (in_pixel),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .coef_wr   (coef_wr),
      .coef_sel  (coef_sel),
      .coef_idx  (coef_idx),
      .coef_data (coef_data),
      .cfg_mode  (cfg_mode),
      .cfg_shift (cfg_shift),
      .out_pixel (out_pixel),
      .out_valid (out_valid),
      .out_sof   (out_sof)
   );

   typedef struct {
      int pix;
      bit sof;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   int   img [ROWS][IMG_W];
   int   ka_sh [9];
   int   kb_sh [9];
   int   ka_act [9];
   int   kb_act [9];
   int   mode_act;
   int   shift_act;
   logic [2:0] hist;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference output for input pixel (x,y) of the current frame
   function automatic int model(input int x, input int y);
      longint a, b, v;
      a = 0;
      b = 0;
      if (x < 2 || y < 2) return 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            a += longint'(img[y-2+r][x-2+c]) * ka_act[r*3+c];
            b += longint'(img[y-2+r][x-2+c]) * kb_act[r*3+c];
         end
      end
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      case (mode_act)
         0:       v = a;
         1:       v = b;
         2:       v = a + b;
         default: v = img[y-1][x-1];
      endcase
      v = v >> shift_act;
      if (v > 4095) v = 4095;
      return int'(v);
   endfunction

   task automatic model_defaults();
      for (int i = 0; i < 9; i++) begin
         ka_sh[i]  = SOBEL_GX[i];
         kb_sh[i]  = SOBEL_GY[i];
         ka_act[i] = SOBEL_GX[i];
         kb_act[i] = SOBEL_GY[i];
      end
      mode_act  = 2;
      shift_act = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      coef_wr  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic set_cfg(input int m, input int s);
      cfg_mode  = 2'(m);
      cfg_shift = 4'(s);
      idle(2);
   endtask

   task automatic wr_coef(input bit sel, input int idx, input int val);
      coef_wr   = 1'b1;
      coef_sel  = sel;
      coef_idx  = 4'(idx);
      coef_data = 8'(val);
      if (idx < 9) begin
         if (sel) kb_sh[idx] = val;
         else     ka_sh[idx] = val;
      end
      tick();
      coef_wr = 1'b0;
   endtask

   task automatic send(input int x, input int y);
      exp_t e;
      in_valid = 1'b1;
      in_sof   = (x == 0 && y == 0);
      in_pixel = 12'(img[y][x]);
      if (x == 0 && y == 0) begin
         ka_act    = ka_sh;
         kb_act    = kb_sh;
         mode_act  = int'(cfg_mode);
         shift_act = int'(cfg_shift);
      end
      e.pix = model(x, y);
      e.sof = (x == 0 && y == 0);
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // kind 0 flat, 1 vertical step at column 4, 2 random
   task automatic fill(input int kind, input int amp);
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            case (kind)
               0:       img[y][x] = amp;
               1:       img[y][x] = (x >= 4) ? amp : 0;
               default: img[y][x] = int'($urandom_range(0, 4095));
            endcase
         end
      end
   endtask

   // Drives one frame; write_at >= 0 loads identity into shadow A before that pixel
   task automatic run_frame(input int bubble_pct, input int write_at);
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            if (y*IMG_W + x == write_at) begin
               for (int i = 0; i < 9; i++) wr_coef(1'b0, i, (i == 4) ? 1 : 0);
               wr_coef(1'b0, 12, 5);
            end
            while (int'($urandom_range(0, 99)) < bubble_pct) idle(1);
            send(x, y);
         end
      end
      idle(6);
      check("drain", exp_q.size(), 0);
   endtask

   // in_valid history, to check the fixed latency
   always @(posedge clk or negedge rst) begin
      if (!rst) hist <= 3'b000;
      else      hist <= {hist[1:0], in_valid};
   end

   // Output monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         check("valid_latency", int'(out_valid), int'(hist[2]));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_pixel", int'(out_pixel), mon_e.pix);
               check("out_sof", int'(out_sof), int'(mon_e.sof));
            end
         end
      end
   end

   initial begin
      rst       = 1'b0;
      in_pixel  = '0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      coef_wr   = 1'b0;
      coef_sel  = 1'b0;
      coef_idx  = '0;
      coef_data = '0;
      cfg_mode  = 2'd2;
      cfg_shift = 4'd0;
      model_defaults();
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_pixel", int'(out_pixel), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_sof", int'(out_sof), 0);
      rst = 1'b1;
      idle(2);

      // flat frame, default Sobel magnitude sum
      fill(0, 100);
      run_frame(0, -1);
      // vertical step, |A|
      set_cfg(0, 0);
      fill(1, 1000);
      run_frame(0, -1);
      // step 2000, |A|+|B| saturates
      set_cfg(2, 0);
      fill(1, 2000);
      run_frame(0, -1);
      // step 1000, shift 2
      set_cfg(0, 2);
      fill(1, 1000);
      run_frame(0, -1);
      // identity written mid-frame: this frame stays Sobel
      set_cfg(0, 0);
      fill(2, 0);
      run_frame(30, 13);
      // next frame uses identity
      fill(2, 0);
      run_frame(30, -1);
      // |B| with shift, then passthrough
      set_cfg(1, 1);
      fill(2, 0);
      run_frame(30, -1);
      set_cfg(3, 0);
      fill(2, 0);
      run_frame(30, -1);

      // reset in the middle of a frame
      set_cfg(0, 0);
      fill(2, 0);
      for (int i = 0; i < 12; i++) send(i % IMG_W, i / IMG_W);
      rst = 1'b0;
      #1;
      check("midrst_out_pixel", int'(out_pixel), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_sof", int'(out_sof), 0);
      exp_q.delete();
      model_defaults();
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);
      fill(2, 0);
      run_frame(0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
